i2c_reg_ctrl: RTL and testbench

- Register-bank controller on the downstream byte interface of the team's I2C slave.
- Interprets each I2C write transaction as: one pointer byte, then data bytes written with auto-increment. Master reads stream bytes from the pointer, also with auto-increment.
- Arbitrates the bank's single write port between the I2C side and a local host port.
- Flags writes and protocol errors to the system.

---
 rtl/i2c_reg_ctrl.sv | 115 +++++++++++
 tb/tb_i2c_reg_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// Register bank behind the I2C slave byte interface: pointer byte then auto-increment
// writes, auto-increment reads, plus a local host port sharing the bank write port.
module i2c_reg_ctrl #(
   parameter int          ADDR_W    = 4,
   parameter logic [7:0]  RESET_VAL = 8'h00
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i2c_start,
   input  logic              i2c_rw,
   input  logic              i2c_stop,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_req,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic              host_ack,
   output logic [7:0]        host_rdata,
   output logic              wr_pulse,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              proto_err
);
   // state      | meaning
   // IDLE       | no transaction addressed to us
   // GET_PTR    | write transaction, next byte is the register pointer
   // WRITE_DATA | write transaction, bytes go to bank[ptr], ptr auto-increments
   // READ_DATA  | read transaction, tx_req streams bank[ptr], ptr auto-increments
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, GET_PTR, WRITE_DATA, READ_DATA} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [7:0]        bank [DEPTH];
   logic              i2c_wr, tx_ok, tx_err, rx_err, host_gnt, host_wr;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      i2c_wr    = 1'b0;
      tx_ok     = 1'b0;
      tx_err    = 1'b0;
      rx_err    = 1'b0;
      // a byte arriving with a new start belongs to neither transaction
      if (rx_valid) begin
         if (i2c_start) begin
            rx_err = 1'b1;
         end else begin
            case (state)
               GET_PTR: begin
                  ptr_nxt   = rx_data[ADDR_W-1:0];
                  state_nxt = WRITE_DATA;
               end
               WRITE_DATA: begin
                  i2c_wr  = 1'b1;
                  ptr_nxt = ptr + ADDR_W'(1);
               end
               default: rx_err = 1'b1;
            endcase
         end
      end
      if (tx_req) begin
         if (state == READ_DATA) begin
            tx_ok   = 1'b1;
            ptr_nxt = ptr + ADDR_W'(1);
         end else begin
            tx_err = 1'b1;
         end
      end
      if (i2c_stop)  state_nxt = IDLE;
      if (i2c_start) state_nxt = i2c_rw ? READ_DATA : GET_PTR;
   end

   // host_ack blocks the grant so a request still held during the ack cycle is not re-served
   assign host_gnt = host_req & ~host_ack & (~host_we | ~i2c_wr);
   assign host_wr  = host_gnt & host_we;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         ptr        <= '0;
         busy       <= 1'b0;
         tx_valid   <= 1'b0;
         tx_data    <= 8'h00;
         proto_err  <= 1'b0;
         wr_pulse   <= 1'b0;
         wr_addr    <= '0;
         host_ack   <= 1'b0;
         host_rdata <= 8'h00;
         for (int i = 0; i < DEPTH; i++) bank[i] <= RESET_VAL;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         busy      <= (state_nxt != IDLE);
         tx_valid  <= tx_ok | tx_err;
         proto_err <= rx_err | tx_err;
         wr_pulse  <= i2c_wr;
         host_ack  <= host_gnt;
         if (tx_ok)       tx_data <= bank[ptr];
         else if (tx_err) tx_data <= 8'hFF;
         if (i2c_wr) begin
            bank[ptr] <= rx_data;
            wr_addr   <= ptr;
         end else if (host_wr) begin
            bank[host_addr] <= host_wdata;
         end
         if (host_gnt && !host_we) host_rdata <= bank[host_addr];
      end
   end
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Testbench for i2c_reg_ctrl: directed vector table, hand sequences for host
// collision and reset, and random byte-event traffic against a transaction-level model.
module tb_i2c_reg_ctrl;
   logic       clock = 1'b0;
   logic       reset_n;
   logic       i2c_start, i2c_rw, i2c_stop, rx_valid, tx_req;
   logic [7:0] rx_data;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       host_req, host_we;
   logic [3:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_ack;
   logic [7:0] host_rdata;
   logic       wr_pulse;
   logic [3:0] wr_addr;
   logic       busy, proto_err;

   i2c_reg_ctrl #(.ADDR_W(4), .RESET_VAL(8'h00)) dut (
      .clock(clock), .reset_n(reset_n),
      .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_stop(i2c_stop),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .wr_pulse(wr_pulse), .wr_addr(wr_addr), .busy(busy), .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   typedef enum int {OP_IDLE, OP_START_W, OP_START_R, OP_STOP, OP_RX, OP_TX,
                     OP_RX_STOP, OP_TX_STOP, OP_START_RX, OP_START_STOP} op_t;

   typedef struct {
      op_t        op;
      logic [7:0] arg;
      bit         wr;
      int         waddr;
      bit         txv;
      int         txd;
      bit         err;
      bit         bsy;
   } vec_t;

   typedef struct {
      bit wr; int waddr; bit txv; int txd; bit err; bit bsy;
   } exp_t;

   localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_RD = 3;

   int         n_tests = 0;
   int         n_fail  = 0;
   vec_t       tbl[$];
   logic [7:0] m_bank [16];
   int         m_ptr;
   int         m_mode;

   task automatic chk(string nm, int act, int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
      m_ptr  = 0;
      m_mode = M_IDLE;
   endtask

   task automatic model_rx(logic [7:0] b, inout exp_t e);
      if (m_mode == M_PTR) begin
         m_ptr  = b % 16;
         m_mode = M_WR;
      end else if (m_mode == M_WR) begin
         e.wr          = 1;
         e.waddr       = m_ptr;
         m_bank[m_ptr] = b;
         m_ptr         = (m_ptr + 1) % 16;
      end else begin
         e.err = 1;
      end
   endtask

   task automatic model_tx(inout exp_t e);
      e.txv = 1;
      if (m_mode == M_RD) begin
         e.txd = m_bank[m_ptr];
         m_ptr = (m_ptr + 1) % 16;
      end else begin
         e.txd = 8'hFF;
         e.err = 1;
      end
   endtask

   task automatic model_step(op_t op, logic [7:0] arg, output exp_t e);
      e = '{0, 0, 0, 0, 0, 0};
      case (op)
         OP_START_W:    m_mode = M_PTR;
         OP_START_R:    m_mode = M_RD;
         OP_STOP:       m_mode = M_IDLE;
         OP_RX:         model_rx(arg, e);
         OP_TX:         model_tx(e);
         OP_RX_STOP:    begin model_rx(arg, e); m_mode = M_IDLE; end
         OP_TX_STOP:    begin model_tx(e);      m_mode = M_IDLE; end
         OP_START_RX:   begin e.err = 1;        m_mode = M_PTR;  end
         OP_START_STOP: m_mode = M_PTR;
         default: ;
      endcase
      e.bsy = (m_mode != M_IDLE);
   endtask

   task automatic apply_op(op_t op, logic [7:0] arg);
      rx_data = arg;
      case (op)
         OP_START_W:    begin i2c_start = 1; i2c_rw = 0; end
         OP_START_R:    begin i2c_start = 1; i2c_rw = 1; end
         OP_STOP:       i2c_stop = 1;
         OP_RX:         rx_valid = 1;
         OP_TX:         tx_req = 1;
         OP_RX_STOP:    begin rx_valid = 1; i2c_stop = 1; end
         OP_TX_STOP:    begin tx_req = 1; i2c_stop = 1; end
         OP_START_RX:   begin i2c_start = 1; i2c_rw = 0; rx_valid = 1; end
         OP_START_STOP: begin i2c_start = 1; i2c_rw = 0; i2c_stop = 1; end
         default: ;
      endcase
      tick();
      i2c_start = 0; i2c_rw = 0; i2c_stop = 0; rx_valid = 0; tx_req = 0;
   endtask

   task automatic compare(string tag, exp_t e);
      chk({tag, ".wr_pulse"}, wr_pulse, e.wr);
      if (e.wr) chk({tag, ".wr_addr"}, wr_addr, e.waddr);
      chk({tag, ".tx_valid"}, tx_valid, e.txv);
      if (e.txv) chk({tag, ".tx_data"}, tx_data, e.txd);
      chk({tag, ".proto_err"}, proto_err, e.err);
      chk({tag, ".busy"}, busy, e.bsy);
   endtask

   task automatic host_op(bit we, logic [3:0] a, logic [7:0] d, output logic [7:0] rd,
                          output int lat);
      host_req = 1; host_we = we; host_addr = a; host_wdata = d;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!host_ack && lat < 20);
      rd = host_rdata;
      host_req = 0; host_we = 0;
      tick();
      chk("host_ack_single_pulse", host_ack, 0);
   endtask

   task automatic host_read_chk(logic [3:0] a, logic [7:0] expv);
      logic [7:0] rd;
      int         lat;
      host_op(0, a, 8'h00, rd, lat);
      chk($sformatf("host_rd_lat[%0h]", a), lat, 1);
      chk($sformatf("bank[%0h]", a), rd, expv);
   endtask

   task automatic add(op_t op, logic [7:0] a, bit wr, int wa, bit txv, int txd, bit err,
                      bit bsy);
      vec_t v;
      v = '{op, a, wr, wa, txv, txd, err, bsy};
      tbl.push_back(v);
   endtask

   initial begin
      exp_t       e;
      logic [7:0] rd;
      int         lat;

      reset_n = 0;
      i2c_start = 0; i2c_rw = 0; i2c_stop = 0; rx_valid = 0; rx_data = 0; tx_req = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      model_reset();
      tick(); tick();
      chk("rst.busy", busy, 0);
      chk("rst.tx_valid", tx_valid, 0);
      chk("rst.tx_data", tx_data, 0);
      chk("rst.wr_pulse", wr_pulse, 0);
      chk("rst.proto_err", proto_err, 0);
      chk("rst.host_ack", host_ack, 0);
      reset_n = 1;
      tick();

      //        op             arg    wr wa   txv txd    err bsy
      add(OP_START_W,    8'h00, 0, 0,   0, 0,     0, 1);
      add(OP_RX,         8'h03, 0, 0,   0, 0,     0, 1);
      add(OP_RX,         8'hAA, 1, 3,   0, 0,     0, 1);
      add(OP_RX,         8'hBB, 1, 4,   0, 0,     0, 1);
      add(OP_STOP,       8'h00, 0, 0,   0, 0,     0, 0);
      add(OP_START_W,    8'h00, 0, 0,   0, 0,     0, 1);
      add(OP_RX,         8'h03, 0, 0,   0, 0,     0, 1);
      add(OP_START_R,    8'h00, 0, 0,   0, 0,     0, 1);
      add(OP_TX,         8'h00, 0, 0,   1, 'hAA,  0, 1);
      add(OP_TX,         8'h00, 0, 0,   1, 'hBB,  0, 1);
      add(OP_START_R,    8'h00, 0, 0,   0, 0,     0, 1);
      add(OP_TX,         8'h00, 0, 0,   1, 'h00,  0, 1);
      add(OP_STOP,       8'h00, 0, 0,   0, 0,     0, 0);
      add(OP_START_W,    8'h00, 0, 0,   0, 0,     0, 1);
      add(OP_RX,         8'h1F, 0, 0,   0, 0,     0, 1);
      add(OP_RX,         8'h11, 1, 15,  0, 0,     0, 1);
      add(OP_RX,         8'h22, 1, 0,   0, 0,     0, 1);
      add(OP_RX,         8'h33, 1, 1,   0, 0,     0, 1);
      add(OP_STOP,       8'h00, 0, 0,   0, 0,     0, 0);
      add(OP_RX,         8'h77, 0, 0,   0, 0,     1, 0);
      add(OP_START_W,    8'h00, 0, 0,   0, 0,     0, 1);
      add(OP_RX,         8'h02, 0, 0,   0, 0,     0, 1);
      add(OP_TX,         8'h00, 0, 0,   1, 'hFF,  1, 1);
      add(OP_RX,         8'h44, 1, 2,   0, 0,     0, 1);
      add(OP_RX_STOP,    8'h55, 1, 3,   0, 0,     0, 0);
      add(OP_START_STOP, 8'h00, 0, 0,   0, 0,     0, 1);
      add(OP_START_RX,   8'h99, 0, 0,   0, 0,     1, 1);
      add(OP_RX,         8'h08, 0, 0,   0, 0,     0, 1);
      add(OP_RX,         8'h66, 1, 8,   0, 0,     0, 1);
      add(OP_TX_STOP,    8'h00, 0, 0,   1, 'hFF,  1, 0);

      foreach (tbl[i]) begin
         exp_t te;
         apply_op(tbl[i].op, tbl[i].arg);
         model_step(tbl[i].op, tbl[i].arg, e);
         te = '{tbl[i].wr, tbl[i].waddr, tbl[i].txv, tbl[i].txd, tbl[i].err, tbl[i].bsy};
         compare($sformatf("vec%0d", i), te);
      end
      host_read_chk(4'h4, 8'hBB);
      host_read_chk(4'hF, 8'h11);
      host_read_chk(4'h0, 8'h22);
      host_read_chk(4'h1, 8'h33);
      host_read_chk(4'h2, 8'h44);
      host_read_chk(4'h3, 8'h55);
      host_read_chk(4'h8, 8'h66);

      // host write colliding with an I2C write to the same register
      apply_op(OP_START_W, 8'h00); model_step(OP_START_W, 8'h00, e);
      apply_op(OP_RX, 8'h05);      model_step(OP_RX, 8'h05, e);
      rx_valid = 1; rx_data = 8'h66;
      host_req = 1; host_we = 1; host_addr = 4'h5; host_wdata = 8'h55;
      tick();
      rx_valid = 0;
      model_step(OP_RX, 8'h66, e);
      chk("coll.wr_pulse", wr_pulse, 1);
      chk("coll.wr_addr", wr_addr, 5);
      chk("coll.ack_early", host_ack, 0);
      tick();
      chk("coll.ack_at_2", host_ack, 1);
      host_req = 0; host_we = 0;
      m_bank[5] = 8'h55;
      tick();
      chk("coll.ack_pulse", host_ack, 0);
      chk("coll.no_wr_pulse", wr_pulse, 0);
      apply_op(OP_STOP, 8'h00); model_step(OP_STOP, 8'h00, e);
      host_read_chk(4'h5, 8'h55);

      // plain host write then read back
      host_op(1, 4'hC, 8'hC3, rd, lat);
      chk("host_wr_lat", lat, 1);
      m_bank[12] = 8'hC3;
      host_read_chk(4'hC, 8'hC3);

      // reset in the middle of a write transaction
      apply_op(OP_START_W, 8'h00);
      apply_op(OP_RX, 8'h07);
      reset_n = 0;
      tick();
      reset_n = 1;
      model_reset();
      chk("rstmid.busy", busy, 0);
      chk("rstmid.wr_pulse", wr_pulse, 0);
      chk("rstmid.tx_data", tx_data, 0);
      for (int i = 0; i < 16; i++) host_read_chk(4'(i), 8'h00);
      apply_op(OP_RX, 8'h5A);
      model_step(OP_RX, 8'h5A, e);
      compare("rstmid.rx_idle", e);
      host_op(1, 4'h0, 8'h5A, rd, lat);
      m_bank[0] = 8'h5A;
      apply_op(OP_START_R, 8'h00); model_step(OP_START_R, 8'h00, e);
      apply_op(OP_TX, 8'h00);      model_step(OP_TX, 8'h00, e);
      compare("rstmid.ptr0", e);
      chk("rstmid.ptr0_data", tx_data, 8'h5A);
      apply_op(OP_STOP, 8'h00);    model_step(OP_STOP, 8'h00, e);

      // random byte-event traffic against the model
      for (int n = 0; n < 600; n++) begin
         op_t        op;
         logic [7:0] a;
         int         r;
         r = $urandom_range(0, 99);
         a = 8'($urandom);
         if      (r < 8)  op = OP_START_W;
         else if (r < 14) op = OP_START_R;
         else if (r < 19) op = OP_STOP;
         else if (r < 50) op = OP_RX;
         else if (r < 72) op = OP_TX;
         else if (r < 75) op = OP_RX_STOP;
         else if (r < 78) op = OP_TX_STOP;
         else if (r < 81) op = OP_START_RX;
         else if (r < 83) op = OP_START_STOP;
         else             op = OP_IDLE;
         apply_op(op, a);
         model_step(op, a, e);
         compare($sformatf("rnd%0d", n), e);
      end
      apply_op(OP_STOP, 8'h00); model_step(OP_STOP, 8'h00, e);
      for (int i = 0; i < 16; i++) host_read_chk(4'(i), m_bank[i]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
